// File: rtl/dmem_responder.sv
// Data-memory responder: memory end of the core's valid/yumi load/store port.
// One request in flight; the array access happens on the accept edge and the response is held until acked.
package dmem_responder_pkg;
  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;
endpackage

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     from_core_i,
  input  logic [31:0] addr_i,
  output mem_out_s    to_core_o,
  output logic        oob_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int         depth_lp     = 1 << addr_width_p;
  localparam logic [3:0] wait_init_lp = 4'(latency_p - 2);
  localparam logic [1:0] accept_nxt_lp = (latency_p == 1) ? RESP : WAIT;

  // Zero-extended byte from the selected lane of a word.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    return {24'd0, shifted[7:0]};
  endfunction

  // One-hot byte enable for a lane.
  function automatic logic [3:0] lane_enable(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  logic [1:0]                 state_r, state_s;
  logic [3:0]                 cnt_r, cnt_s;
  logic [31:0]                read_data_r, read_data_s;
  logic                       valid_r;
  logic                       oob_r, oob_s;
  logic                       yumi_s;
  logic                       accept_s;
  logic                       in_range_s;
  logic [addr_width_p-1:0]    word_idx_s;
  logic [1:0]                 lane_s;
  logic                       mem_we_s;
  logic [3:0]                 mem_be_s;
  logic [31:0]                mem_wdata_s;
  logic [31:0]                mem_r [depth_lp];

  assign word_idx_s = addr_i[addr_width_p+1:2];
  assign lane_s     = addr_i[1:0];
  assign in_range_s = ~|addr_i[31:addr_width_p+2];

  // Handshake: yumi only from IDLE, never from the core's own yumi.
  always_comb begin
    yumi_s = 1'b0;
    if (state_r == IDLE) begin
      yumi_s = from_core_i.valid & reset;
    end else begin
      yumi_s = 1'b0;
    end
    accept_s = from_core_i.valid & yumi_s;
  end

  // Next-state and latency counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = accept_nxt_lp;
          cnt_s   = wait_init_lp;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = RESP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (from_core_i.yumi) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Access decode at accept: array write enables, response data and out-of-range flag.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_be_s    = 4'b0000;
    mem_wdata_s = 32'd0;
    read_data_s = read_data_r;
    oob_s       = oob_r;
    if (accept_s) begin
      if (!in_range_s) begin
        oob_s       = 1'b1;
        read_data_s = 32'd0;
      end else if (from_core_i.wen) begin
        mem_we_s    = 1'b1;
        read_data_s = 32'd0;
        if (from_core_i.byte_not_word) begin
          mem_be_s    = lane_enable(lane_s);
          mem_wdata_s = {4{from_core_i.write_data[7:0]}};
        end else begin
          mem_be_s    = 4'b1111;
          mem_wdata_s = from_core_i.write_data;
        end
      end else if (from_core_i.byte_not_word) begin
        read_data_s = lane_extract(mem_r[word_idx_s], lane_s);
      end else begin
        read_data_s = mem_r[word_idx_s];
      end
    end else begin
      read_data_s = read_data_r;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      read_data_r <= 32'd0;
      valid_r     <= 1'b0;
      oob_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      read_data_r <= read_data_s;
      valid_r     <= (state_s == RESP);
      oob_r       <= oob_s;
    end
  end

  // Byte-enabled storage array; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_s && mem_be_s[i]) begin
        mem_r[word_idx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
      end
    end
  end

  assign to_core_o = '{read_data: read_data_r, valid: valid_r, yumi: yumi_s};
  assign oob_o     = oob_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// handshake/reset sequences and randomized traffic against a behavioural model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam logic [31:0] OOB_BASE = 32'h0000_1000;

  logic        clk;
  logic        reset;
  mem_in_s     from_core_i;
  logic [31:0] addr_i;
  mem_out_s    to_core_o;
  logic        oob_o;

  int n_cmp;
  int n_bad;

  dmem_responder #(.addr_width_p(AW), .latency_p(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .from_core_i(from_core_i),
    .addr_i     (addr_i),
    .to_core_o  (to_core_o),
    .oob_o      (oob_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic        bnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_oob;
  } vec_t;

  vec_t vecs[18];

  logic [31:0] mdl [int];
  logic        mdl_oob;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic wen, input logic bnw, input logic [31:0] addr, input logic [31:0] wdata);
    from_core_i.valid         = 1'b1;
    from_core_i.wen           = wen;
    from_core_i.byte_not_word = bnw;
    from_core_i.write_data    = wdata;
    addr_i                    = addr;
  endtask

  // Present a request and return in the cycle it is accepted.
  task automatic issue(input logic wen, input logic bnw, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    drive_req(wen, bnw, addr, wdata);
    #1;
    n = 0;
    while (!to_core_o.yumi && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept", {31'd0, to_core_o.yumi}, 32'd1);
  endtask

  // Wait for the response, hold it 'hold' cycles, then ack. With chain set a new
  // request is presented during the hold and must be accepted at Tr+1.
  task automatic collect(input logic [31:0] exp, input int hold, input logic chain,
                         input logic cwen, input logic cbnw, input logic [31:0] caddr,
                         input logic [31:0] cwdata);
    int k;
    logic [31:0] held;
    @(negedge clk);
    from_core_i.valid = 1'b0;
    #1;
    k = 1;
    while (!to_core_o.valid && k <= 20) begin
      chk("yumi_wait", {31'd0, to_core_o.yumi}, 32'd0);
      @(negedge clk);
      #1;
      k++;
    end
    chk("latency", k, LAT);
    chk("read_data", to_core_o.read_data, exp);
    held = to_core_o.read_data;
    for (int h = 0; h < hold; h++) begin
      if (chain) drive_req(cwen, cbnw, caddr, cwdata);
      #1;
      chk("hold_yumi", {31'd0, to_core_o.yumi}, 32'd0);
      chk("hold_valid", {31'd0, to_core_o.valid}, 32'd1);
      chk("hold_data", to_core_o.read_data, held);
      @(negedge clk);
    end
    from_core_i.yumi = 1'b1;
    #1;
    chk("resp_yumi", {31'd0, to_core_o.yumi}, 32'd0);
    chk("resp_valid", {31'd0, to_core_o.valid}, 32'd1);
    @(negedge clk);
    from_core_i.yumi = 1'b0;
    #1;
    chk("valid_drop", {31'd0, to_core_o.valid}, 32'd0);
    if (chain) chk("accept_tr1", {31'd0, to_core_o.yumi}, 32'd1);
  endtask

  // Reference model: word-addressed memory with byte masks, out-of-range never touches it.
  task automatic model_op(input logic wen, input logic bnw, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] exp);
    int idx;
    int sh;
    if (addr >= OOB_BASE) begin
      mdl_oob = 1'b1;
      exp = 32'd0;
    end else begin
      idx = int'(addr / 32'd4);
      sh  = 8 * int'(addr % 32'd4);
      if (wen) begin
        if (bnw) mdl[idx] = (mdl[idx] & ~(32'h0000_00FF << sh)) | ((wdata & 32'h0000_00FF) << sh);
        else     mdl[idx] = wdata;
        exp = 32'd0;
      end else if (bnw) begin
        exp = (mdl[idx] >> sh) & 32'h0000_00FF;
      end else begin
        exp = mdl[idx];
      end
    end
  endtask

  initial begin
    logic [31:0] a, wd, exp;
    logic        w, b;
    n_cmp = 0;
    n_bad = 0;
    mdl_oob = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0011, 32'h5555_55AB, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0011, 32'h0000_0000, 32'h0000_00AB, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1234_AB78, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0000, 32'h0000_00CA, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_000D, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_0002, 32'hFFFF_FF11, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hCA11_F00D, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0016, 32'hA5A5_0F0F, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0000_0000, 32'hA5A5_0F0F, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hCA11_F00D, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 32'h0000_0FFF, 32'h0000_0000, 32'h0000_00DE, 1'b1};

    // Reset with a request pending at the input.
    reset = 1'b0;
    from_core_i = '0;
    addr_i = 32'd0;
    from_core_i.valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, to_core_o.valid}, 32'd0);
    chk("rst_yumi", {31'd0, to_core_o.yumi}, 32'd0);
    chk("rst_rdata", to_core_o.read_data, 32'd0);
    chk("rst_oob", {31'd0, oob_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_yumi", {31'd0, to_core_o.yumi}, 32'd1);
    from_core_i.valid = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].wen, vecs[i].bnw, vecs[i].addr, vecs[i].wdata);
      collect(vecs[i].exp_rd, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("oob_vec", {31'd0, oob_o}, {31'd0, vecs[i].exp_oob});
    end

    // Held response with a new request waiting behind it.
    issue(1'b0, 1'b0, 32'h0000_0010, 32'd0);
    collect(32'h1234_AB78, 3, 1'b1, 1'b0, 1'b1, 32'h0000_0011, 32'd0);
    collect(32'h0000_00AB, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset while the latency counter is running.
    issue(1'b0, 1'b0, 32'h0000_0010, 32'd0);
    @(negedge clk);
    from_core_i.valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, to_core_o.valid}, 32'd0);
    chk("midrst_oob", {31'd0, oob_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("midrst_idle_valid", {31'd0, to_core_o.valid}, 32'd0);
    end
    issue(1'b0, 1'b0, 32'h0000_0010, 32'd0);
    collect(32'h1234_AB78, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Randomized traffic against the model; seed the first 16 words first.
    for (int i = 0; i < 16; i++) begin
      a = 32'(i * 4);
      wd = $urandom;
      model_op(1'b1, 1'b0, a, wd, exp);
      issue(1'b1, 1'b0, a, wd);
      collect(exp, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a < OOB_BASE) a = a + OOB_BASE;
      end else begin
        a = 32'($urandom_range(0, 63));
      end
      model_op(w, b, a, wd, exp);
      issue(w, b, a, wd);
      collect(exp, int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("oob_rand", {31'd0, oob_o}, {31'd0, mdl_oob});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the core's load/store port: the memory end of the `mem_in_s` / `mem_out_s` valid/yumi handshake that the core initiates. It accepts one request at a time, performs the word or byte access on a local synchronous array after a programmable latency, and holds the response until the core acknowledges it. It sits beside the core in the tile, driven by the core's `to_mem_o` / `data_mem_addr`, and drives the core's `from_mem_i`.

## Interface
- `addr_width_p`, 10: log2 of memory depth in 32-bit words.
- `latency_p`, 2: cycles from accept edge to response valid; legal range 1..15.
- `clk` input, 1 bit: clock; single clock domain, all state on rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `from_core_i` input, `mem_in_s`: request from core; fields `write_data`, `valid`, `wen`, `byte_not_word`, `yumi`.
- `addr_i` input, 32 bits: byte address of the request (core's `data_mem_addr`).
- `to_core_o` output, `mem_out_s`: fields `read_data` (32 bits), `valid`, `yumi`.
- `oob_o` output, 1 bit: sticky out-of-range-access flag.

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: `to_core_o.yumi = from_core_i.valid & reset`, combinational. On an accept edge (valid & yumi), latch `wen`, `byte_not_word`, `write_data`, `addr_i`. Go to RESP if `latency_p==1`, else WAIT with counter = `latency_p-2`.
- WAIT: counter decrements each cycle; at counter 0 go to RESP. `yumi` = 0.
- RESP: `to_core_o.valid` = 1, `read_data` stable. If `from_core_i.yumi` = 1, go to IDLE. `yumi` = 0; new requests are ignored until IDLE.
- Address decode: word index = `addr_i[31:2]`, lane = `addr_i[1:0]`. In range iff word index < 2^`addr_width_p`.
- Word store: writes `write_data` to the word; `addr_i[1:0]` ignored. Byte store: writes `write_data[7:0]` to lane `addr_i[1:0]` only; the other lanes are unchanged.
- Word load: `read_data` = word. Byte load: `read_data` = {24'b0, selected lane}.
- Stores return `read_data` = 0.
- Array write and read capture happen on the accept edge. The response register is loaded then and presented in RESP.
- Out of range: no array write, `read_data` = 0, `oob_o` set on the accept edge. The response is still returned (no hang). `oob_o` clears only on reset.
- Array contents are not reset.

## Timing
- Reset values: `to_core_o.valid` 0, `to_core_o.yumi` 0, `to_core_o.read_data` 0, `oob_o` 0. Reset acts immediately (asynchronously), including mid-WAIT or mid-RESP. The pending request is dropped.
- Accept edge at cycle T0. `valid` is high from cycle T0+`latency_p` until the cycle the core asserts `yumi` (Tr), inclusive. `valid` is low at Tr+1.
- The earliest next accept is Tr+1. The minimum request-to-request spacing is `latency_p`+1 cycles.
- `read_data` outside RESP: holds its last value (0 after reset).
- `yumi` depends only on the current state and `from_core_i.valid`; it never depends on `from_core_i.yumi`, so there is no combinational loop.
- A core `yumi` outside RESP is ignored.

## Test plan
- Reset: drive `reset`=0 while `from_core_i.valid`=1. Required: all outputs 0 and `yumi` 0. Release reset: `yumi` goes high the same cycle.
- Word round trip, `latency_p`=2: store 0x12345678 at 0x10, with core `yumi` the same cycle as `valid`. Required: `valid` at T0+2 with `read_data` 0. Then load 0x10: `read_data` = 0x12345678 at T0+2.
- Byte lanes: after the word round trip, byte store 0xAB to 0x11. Required: byte load 0x11 returns 0x000000AB; word load 0x10 returns 0x1234AB78.
- Held response: hold core `yumi` low for 3 cycles in RESP while presenting a new `valid`. Required: `valid`/`read_data` stable, `to_core_o.yumi` 0 throughout; the new request is accepted at Tr+1.
- Out of range, `addr_width_p`=10: store 0xFFFFFFFF to 0x1000. Required: response `read_data` 0 and `oob_o`=1 thereafter. A word load of 0x0 is unchanged (no aliasing).
- Reset mid-operation: assert `reset` during WAIT. Required: `valid` never rises and state is IDLE. After release, a load of 0x10 completes normally; the array keeps its contents.
